// File: rtl/corelet_inst_seq.sv
// corelet_inst_seq: sequences the corelet inst bus through one convolution pass.
// Define CORELET_INST_SEQ_ACC_EN to add the pmem read-back (ACC) phase before done.

module corelet_inst_seq #(
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int w_base   = 1024,
  parameter int load_gap = 10,
  parameter int addr_bw  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
);

  localparam int AW = addr_bw;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  localparam logic [15:0] C_COL = 16'(col);
  localparam logic [15:0] C_NIJ = 16'(len_nij);
  localparam logic [15:0] C_GAP = 16'(load_gap);
  localparam logic [7:0]  K_LAST = 8'(len_kij - 1);
`ifdef CORELET_INST_SEQ_ACC_EN
  localparam logic [15:0] C_NK  = 16'(len_nij * len_kij);
`endif

  localparam logic [AW-1:0] A_BASE = AW'(w_base);
  localparam logic [AW-1:0] A_COL  = AW'(col);
  localparam logic [AW-1:0] A_NIJ  = AW'(len_nij);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WFETCH,
    S_WLOAD,
    S_AFETCH,
    S_EXEC,
    S_DRAIN,
    S_ACC,
    S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [7:0]  r_kij;
  logic [7:0]  w_kij_nxt;
  logic [15:0] r_nrd;
  logic [15:0] w_nrd_nxt;
  logic [15:0] r_nwr;
  logic [15:0] w_nwr_nxt;

  logic [33:0] r_inst;
  logic        r_busy;
  logic        r_done;
  logic [33:0] w_inst_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  logic        w_rd_now;
  logic        w_wr_now;

  // The registered bus says what happens in the current cycle.
  assign w_rd_now = r_inst[6];
  assign w_wr_now = ~r_inst[31];

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_kij   <= '0;
      r_nrd   <= '0;
      r_nwr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_kij   <= w_kij_nxt;
      r_nrd   <= w_nrd_nxt;
      r_nwr   <= w_nwr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_kij_nxt   = r_kij;
    w_nrd_nxt   = r_nrd;
    w_nwr_nxt   = r_nwr;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WFETCH;
          w_cnt_nxt   = '0;
          w_kij_nxt   = '0;
        end
      end
      S_WFETCH: begin
        if (r_cnt == C_COL) begin
          w_state_nxt = S_WLOAD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_WLOAD: begin
        if (r_cnt == C_COL + C_GAP - 16'd1) begin
          w_state_nxt = S_AFETCH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_AFETCH: begin
        if (r_cnt == C_NIJ) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_EXEC: begin
        if (r_cnt == C_NIJ - 16'd1) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
          w_nrd_nxt   = '0;
          w_nwr_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DRAIN: begin
        w_nrd_nxt = r_nrd + (w_rd_now ? 16'd1 : 16'd0);
        w_nwr_nxt = r_nwr + (w_wr_now ? 16'd1 : 16'd0);
        if (w_wr_now && (r_nwr == C_NIJ - 16'd1)) begin
          w_cnt_nxt = '0;
          if (r_kij == K_LAST) begin
`ifdef CORELET_INST_SEQ_ACC_EN
            w_state_nxt = S_ACC;
            w_nrd_nxt   = '0;
            w_nwr_nxt   = '0;
`else
            w_state_nxt = S_FIN;
`endif
          end else begin
            w_state_nxt = S_WFETCH;
            w_kij_nxt   = r_kij + 8'd1;
          end
        end
      end
      S_ACC: begin
`ifdef CORELET_INST_SEQ_ACC_EN
        // r_nrd walks rows (n), r_nwr walks kernel positions (k, inner).
        if (r_cnt == C_NK) begin
          w_state_nxt = S_FIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_nwr == 16'(K_LAST)) begin
            w_nwr_nxt = '0;
            w_nrd_nxt = r_nrd + 16'd1;
          end else begin
            w_nwr_nxt = r_nwr + 16'd1;
          end
        end
`else
        w_state_nxt = S_FIN;
`endif
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_inst_nxt = IDLE_INST;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_FIN);
    unique case (w_state_nxt)
      S_WFETCH: begin
        if (w_cnt_nxt < C_COL) begin
          w_inst_nxt[19]      = 1'b0;
          w_inst_nxt[7 +: AW] = A_BASE + AW'(w_kij_nxt) * A_COL
                              + AW'(w_cnt_nxt);
        end
        if (w_cnt_nxt != 16'd0) w_inst_nxt[2] = 1'b1;
      end
      S_WLOAD: begin
        if (w_cnt_nxt < C_COL) begin
          w_inst_nxt[3] = 1'b1;
          w_inst_nxt[0] = 1'b1;
        end
      end
      S_AFETCH: begin
        if (w_cnt_nxt < C_NIJ) begin
          w_inst_nxt[19]      = 1'b0;
          w_inst_nxt[7 +: AW] = AW'(w_cnt_nxt);
        end
        if (w_cnt_nxt != 16'd0) w_inst_nxt[2] = 1'b1;
      end
      S_EXEC: begin
        w_inst_nxt[3] = 1'b1;
        w_inst_nxt[1] = 1'b1;
      end
      S_DRAIN: begin
        if (ofifo_valid && (w_nrd_nxt < C_NIJ)) w_inst_nxt[6] = 1'b1;
        if (w_rd_now) begin
          w_inst_nxt[32]       = 1'b0;
          w_inst_nxt[31]       = 1'b0;
          w_inst_nxt[20 +: AW] = AW'(w_kij_nxt) * A_NIJ + AW'(w_nwr_nxt);
        end
      end
`ifdef CORELET_INST_SEQ_ACC_EN
      S_ACC: begin
        if (w_cnt_nxt < C_NK) begin
          w_inst_nxt[32]       = 1'b0;
          w_inst_nxt[20 +: AW] = AW'(w_nwr_nxt) * A_NIJ + AW'(w_nrd_nxt);
        end
        if (w_cnt_nxt != 16'd0) w_inst_nxt[33] = 1'b1;
      end
`endif
      default: begin
        w_inst_nxt = IDLE_INST;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst <= IDLE_INST;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_inst <= w_inst_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

endmodule
